// File: rtl/alu_pipe_param_if.sv
// alu_pipe_param_if: operation/result handshake bundle between the datapath and the registered ALU
interface alu_pipe_param_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] port_A;
    logic [WIDTH-1:0] port_B;
    logic [3:0]       cmd;
    logic [1:0]       OP;
    logic             set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_output;
    logic [3:0]       ALU_Flags;
    logic             busy;
    modport master (
        output in_valid, port_A, port_B, cmd, OP, set_flags, out_ready,
        input  in_ready, out_valid, ALU_output, ALU_Flags, busy
    );
    modport slave (
        input  in_valid, port_A, port_B, cmd, OP, set_flags, out_ready,
        output in_ready, out_valid, ALU_output, ALU_Flags, busy
    );
endinterface

// File: rtl/alu_pipe_param.sv
// alu_pipe_param: registered ALU with NZCV flags, valid/ready handshake and iterative shift-add MUL
module alu_pipe_param #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input logic             clk,
    input logic             reset,
    alu_pipe_param_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [3:0] CMD_MUL = 4'b1001;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             mul_upd_q, mul_upd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [3:0]       flags_q, flags_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] ax, bx, res;
    logic [WIDTH:0]   sum;
    logic             ci, arith, v, upd, is_mul, ready, accept;
    // Subtracts are folded into the adder as x + ~y + carry_in, so C is NOT borrow for free.
    always_comb begin
        ax = bus.port_A;
        bx = bus.port_B;
        ci = 1'b0;
        arith = 1'b0;
        if (bus.OP == 2'b00) begin
            case (bus.cmd)
                4'b0010, CMD_CMP: begin bx = ~bus.port_B; ci = 1'b1; arith = 1'b1; end
                4'b0011: begin ax = bus.port_B; bx = ~bus.port_A; ci = 1'b1; arith = 1'b1; end
                4'b0100: arith = 1'b1;
                4'b0101: begin ci = flags_q[1]; arith = 1'b1; end
                4'b0110: begin bx = ~bus.port_B; ci = flags_q[1]; arith = 1'b1; end
                default: ;
            endcase
        end else if (bus.OP == 2'b01 && !bus.cmd[3]) begin
            bx = ~bus.port_B;
            ci = 1'b1;
        end
        sum = {1'b0, ax} + {1'b0, bx} + {{WIDTH{1'b0}}, ci};
        res = '0;
        if (bus.OP == 2'b00) begin
            case (bus.cmd)
                4'b0000: res = bus.port_A & bus.port_B;
                4'b0001: res = bus.port_A ^ bus.port_B;
                4'b1100: res = bus.port_A | bus.port_B;
                4'b1101: res = bus.port_B;
                default: res = arith ? sum[WIDTH-1:0] : '0;
            endcase
        end else if (bus.OP != 2'b11) begin
            res = sum[WIDTH-1:0];
        end
        v = (ax[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != ax[WIDTH-1]);
        upd = (bus.OP == 2'b00) && (bus.set_flags || bus.cmd == CMD_CMP);
        is_mul = MUL_EN && bus.OP == 2'b00 && bus.cmd == CMD_MUL;
        ready = state_q == IDLE && (!out_valid_q || bus.out_ready);
        accept = bus.in_valid && ready;
    end
    always_comb begin
        state_d = state_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        result_d = result_q;
        flags_d = flags_q;
        acc_d = acc_q;
        mcand_d = mcand_q;
        mplier_d = mplier_q;
        cnt_d = cnt_q;
        mul_upd_d = mul_upd_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mul) begin
                    state_d = MUL;
                    acc_d = '0;
                    mcand_d = bus.port_A;
                    mplier_d = bus.port_B;
                    cnt_d = '0;
                    mul_upd_d = upd;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d = res;
                    flags_d = upd ? {res[WIDTH-1], res == '0, arith ? sum[WIDTH] : flags_q[1], arith ? v : flags_q[0]} : flags_q;
                end
            end
            MUL: begin
                acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
                mcand_d = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d = cnt_q + 1'b1;
                state_d = cnt_q == CW'(WIDTH - 1) ? DONE : MUL;
            end
            DONE: begin
                if (!out_valid_q || bus.out_ready) begin
                    state_d = IDLE;
                    out_valid_d = 1'b1;
                    result_d = acc_q;
                    flags_d = mul_upd_q ? {acc_q[WIDTH-1], acc_q == '0, flags_q[1:0]} : flags_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            out_valid_q <= 1'b0;
            result_q <= '0;
            flags_q <= '0;
            acc_q <= '0;
            mcand_q <= '0;
            mplier_q <= '0;
            cnt_q <= '0;
            mul_upd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_valid_q <= out_valid_d;
            result_q <= result_d;
            flags_q <= flags_d;
            acc_q <= acc_d;
            mcand_q <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q <= cnt_d;
            mul_upd_q <= mul_upd_d;
        end
    end
    assign bus.in_ready = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.ALU_output = result_q;
    assign bus.ALU_Flags = flags_q;
    assign bus.busy = state_q == MUL;
endmodule

// File: tb/tb_alu_pipe_param.sv
// tb_alu_pipe_param: directed and randomized checks of alu_pipe_param against an arithmetic reference model
module tb_alu_pipe_param;
    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  mflags;
    logic [31:0] exp_r;
    alu_pipe_param_if #(.WIDTH(32)) bus ();
    alu_pipe_param #(.WIDTH(32), .MUL_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic ovf(input longint x);
        return x > 64'sd2147483647 || x < -64'sd2147483648;
    endfunction
    function automatic longint sx(input logic [31:0] x);
        return longint'($signed(x));
    endfunction
    function automatic longint ux(input logic [31:0] x);
        return longint'({32'b0, x});
    endfunction
    // Reference: plain 64-bit arithmetic; C from unsigned range, V from signed range.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] r;
        logic [63:0] p;
        logic        cy, vf;
        longint      ci;
        r = '0;
        cy = mflags[1];
        vf = mflags[0];
        ci = mflags[1] ? 1 : 0;
        case (op)
            2'b01: r = c[3] ? a + b : a - b;
            2'b10: r = a + b;
            2'b11: r = '0;
            default: begin
                case (c)
                    4'd0: r = a & b;
                    4'd1: r = a ^ b;
                    4'd2, 4'd10: begin r = a - b; cy = ux(a) >= ux(b); vf = ovf(sx(a) - sx(b)); end
                    4'd3: begin r = b - a; cy = ux(b) >= ux(a); vf = ovf(sx(b) - sx(a)); end
                    4'd4: begin r = a + b; cy = ux(a) + ux(b) > 64'sd4294967295; vf = ovf(sx(a) + sx(b)); end
                    4'd5: begin r = a + b + 32'(ci); cy = ux(a) + ux(b) + ci > 64'sd4294967295; vf = ovf(sx(a) + sx(b) + ci); end
                    4'd6: begin r = a - b - 32'(1 - ci); cy = ux(a) >= ux(b) + 1 - ci; vf = ovf(sx(a) - sx(b) - (1 - ci)); end
                    4'd9: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
                    4'd12: r = a | b;
                    4'd13: r = b;
                    default: r = '0;
                endcase
                if (s || c == 4'd10) mflags = {r[31], r == 32'd0, cy, vf};
            end
        endcase
        return r;
    endfunction
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h1;
            default: return $urandom;
        endcase
    endfunction
    task automatic issue(input logic [1:0] op, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic s);
        int n = 0;
        @(negedge clk);
        bus.OP = op;
        bus.cmd = c;
        bus.port_A = a;
        bus.port_B = b;
        bus.set_flags = s;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        exp_r = model(op, c, a, b, s);
    endtask
    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask
    task automatic test_reset;
        int seen = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.OP = 2'b00;
        bus.cmd = 4'd0;
        bus.port_A = '0;
        bus.port_B = '0;
        bus.set_flags = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mflags = 4'b0000;
        checks++;
        if ({bus.out_valid, bus.busy, bus.in_ready, bus.ALU_Flags, bus.ALU_output} !== {3'b001, 4'b0000, 32'h0}) begin
            errors++;
            $display("FAIL reset_state got v%b b%b r%b f%b o%h required v0 b0 r1 f0000 o0", bus.out_valid, bus.busy, bus.in_ready, bus.ALU_Flags, bus.ALU_output);
        end
        issue(2'b00, 4'b0010, 32'h8000_0000, 32'h1, 1'b1);
        checks++;
        if (bus.ALU_Flags !== 4'b0011) begin
            errors++;
            $display("FAIL pre_reset_flags got %b required 0011", bus.ALU_Flags);
        end
        issue(2'b00, 4'b1001, 32'h1234_5678, 32'h9ABC_DEF1, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_mul_busy got %b required 1", bus.busy);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mflags = 4'b0000;
        checks++;
        if ({bus.out_valid, bus.ALU_Flags, bus.busy, bus.in_ready} !== 7'b0_0000_0_1) begin
            errors++;
            $display("FAIL reset_mid_mul got v%b f%b b%b r%b required v0 f0000 b0 r1", bus.out_valid, bus.ALU_Flags, bus.busy, bus.in_ready);
        end
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL discarded_mul got out_valid_cycles=%0d required 0", seen);
        end
    endtask
    task automatic test_add_adc;
        issue(2'b00, 4'b0100, 32'hFFFF_FFFF, 32'h1, 1'b1);
        checks++;
        if ({bus.out_valid, bus.ALU_output, bus.ALU_Flags} !== {1'b1, 32'h0, 4'b0110}) begin
            errors++;
            $display("FAIL add_wrap got v%b %h f%b required v1 00000000 f0110", bus.out_valid, bus.ALU_output, bus.ALU_Flags);
        end
        issue(2'b00, 4'b0101, 32'h0, 32'h0, 1'b1);
        checks++;
        if ({bus.ALU_output, bus.ALU_Flags} !== {32'h1, 4'b0000}) begin
            errors++;
            $display("FAIL adc_carry_in got %h f%b required 00000001 f0000", bus.ALU_output, bus.ALU_Flags);
        end
    endtask
    task automatic test_cmp_sub;
        issue(2'b00, 4'b1010, 32'd5, 32'd7, 1'b0);
        checks++;
        if ({bus.ALU_output, bus.ALU_Flags} !== {32'hFFFF_FFFE, 4'b1000}) begin
            errors++;
            $display("FAIL cmp_no_s got %h f%b required fffffffe f1000", bus.ALU_output, bus.ALU_Flags);
        end
        issue(2'b00, 4'b0010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if ({bus.ALU_output, bus.ALU_Flags} !== {32'h8000_0000, 4'b1000}) begin
            errors++;
            $display("FAIL sub_no_s got %h f%b required 80000000 f1000", bus.ALU_output, bus.ALU_Flags);
        end
    endtask
    task automatic test_sub_op01;
        issue(2'b00, 4'b0010, 32'h8000_0000, 32'h1, 1'b1);
        checks++;
        if ({bus.ALU_output, bus.ALU_Flags} !== {32'h7FFF_FFFF, 4'b0011}) begin
            errors++;
            $display("FAIL sub_overflow got %h f%b required 7fffffff f0011", bus.ALU_output, bus.ALU_Flags);
        end
        issue(2'b01, 4'b0000, 32'h100, 32'h4, 1'b1);
        checks++;
        if ({bus.ALU_output, bus.ALU_Flags} !== {32'hFC, 4'b0011}) begin
            errors++;
            $display("FAIL op01_sub got %h f%b required 000000fc f0011", bus.ALU_output, bus.ALU_Flags);
        end
    endtask
    task automatic test_mul;
        int k = 0;
        int bc = 0;
        int bad = 0;
        issue(2'b00, 4'b1001, 32'h0001_0003, 32'h5, 1'b1);
        bus.port_A = $urandom;
        bus.port_B = $urandom;
        bus.cmd = 4'($urandom);
        while (!bus.out_valid && k < 60) begin
            if (bus.busy) bc++;
            if (bus.busy && bus.in_ready) bad++;
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (k != 33 || bc != 32 || bad != 0) begin
            errors++;
            $display("FAIL mul_timing got latency=%0d busy=%0d ready_while_busy=%0d required 33 32 0", k, bc, bad);
        end
        checks++;
        if ({bus.ALU_output, bus.ALU_Flags} !== {32'h0005_000F, 4'b0011}) begin
            errors++;
            $display("FAIL mul_result got %h f%b required 0005000f f0011", bus.ALU_output, bus.ALU_Flags);
        end
        repeat (3) begin
            issue(2'b00, 4'b1001, $urandom, $urandom, 1'($urandom_range(0, 1)));
            wait_valid(k);
            checks++;
            if (k != 33 || bus.ALU_output !== exp_r || bus.ALU_Flags !== mflags) begin
                errors++;
                $display("FAIL mul_random got lat=%0d %h f%b required lat=33 %h f%b", k, bus.ALU_output, bus.ALU_Flags, exp_r, mflags);
            end
        end
    endtask
    task automatic test_back_to_back;
        logic [31:0] r0;
        issue(2'b00, 4'b0000, $urandom, $urandom, 1'b1);
        r0 = exp_r;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.OP = 2'b00;
                bus.cmd = 4'b0001;
                bus.port_A = $urandom;
                bus.port_B = $urandom;
                bus.set_flags = 1'b1;
                bus.in_valid = 1'b1;
            end
            checks++;
            if ({bus.out_valid, bus.in_ready} !== 2'b10 || bus.ALU_output !== r0) begin
                errors++;
                $display("FAIL hold_%0d got v%b r%b %h required v1 r0 %h", i, bus.out_valid, bus.in_ready, bus.ALU_output, r0);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL retire_accept_ready got %b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        exp_r = model(2'b00, 4'b0001, bus.port_A, bus.port_B, 1'b1);
        checks++;
        if ({bus.out_valid, bus.ALU_output, bus.ALU_Flags} !== {1'b1, exp_r, mflags}) begin
            errors++;
            $display("FAIL xor_after_retire got v%b %h f%b required v1 %h f%b", bus.out_valid, bus.ALU_output, bus.ALU_Flags, exp_r, mflags);
        end
    endtask
    task automatic test_random;
        logic [1:0] op;
        logic [3:0] c;
        int n;
        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            c = 4'($urandom_range(0, 15));
            if (c == 4'd9 && $urandom_range(0, 3) != 0) c = 4'd5;
            issue(op, c, pick(), pick(), 1'($urandom_range(0, 1)));
            wait_valid(n);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.ALU_output !== exp_r || bus.ALU_Flags !== mflags) begin
                errors++;
                $display("FAIL random_%0d op%b cmd%b got v%b %h f%b required v1 %h f%b", i, op, c, bus.out_valid, bus.ALU_output, bus.ALU_Flags, exp_r, mflags);
            end
        end
    endtask
    initial begin
        test_reset();
        test_add_adc();
        test_cmp_sub();
        test_sub_op01();
        test_mul();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
